corexy_move_sequencer: RTL

- Command sequencer in front of the CoreXY stepper pair driver.
- Accepts Cartesian moves (dx, dy, per-motor half-period) into a small FIFO and converts each to CoreXY motor steps (A = dx+dy, B = dx−dy).
- Issues each move with the driver's start/busy handshake and checks the residual step counts to detect limit-switch aborts.
- Latches a fault and flushes the queue on abort.

---
 rtl/corexy_pkg.sv | 37 +++
 rtl/move_fifo.sv | 61 ++++++
 rtl/corexy_move_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/corexy_pkg.sv
// corexy_pkg: shared types for the CoreXY move sequencer.
//   state_t - sequencer FSM states
//   FLT_*   - fault_code encodings
//   cmd_t   - queued Cartesian command (dx/dy already sign-extended to 32b)
//   motor_a/motor_b - CoreXY kinematics, A = dx+dy, B = dx-dy
package corexy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_CHECK,
    S_FAULT
  } state_t;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_LIMIT   = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] speed_a;
    logic [31:0] speed_b;
  } cmd_t;

  // Operands are sign-extended from DW <= 31 bits, so neither sum overflows.
  function automatic logic [31:0] motor_a(cmd_t c);
    return c.dx + c.dy;
  endfunction

  function automatic logic [31:0] motor_b(cmd_t c);
    return c.dx - c.dy;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: synchronous FIFO with occupancy output and synchronous flush.
//   clk, rst     - clock, async active-high reset
//   push, din    - write; ignored when full unless a pop happens the same cycle
//   pop, dout    - read; dout shows the head combinationally, pop ignored when empty
//   flush        - empties the FIFO at the next edge; wins over a same-cycle push
//   full, empty, level - status (level spans 0..DEPTH)
module move_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/corexy_move_sequencer.sv
// corexy_move_sequencer: queues Cartesian moves and issues them to the CoreXY
// stepper pair driver as A = dx+dy, B = dx-dy with a start/busy handshake.
//   cmd_*        - command input (valid/ready), dx/dy signed DW bits
//   flush        - drop queued commands (an in-flight move still completes)
//   fault_clr    - leave FAULT, clearing fault/fault_code
//   stp_*        - driver interface: operands, start level, enable, busy, residuals
//   busy, level  - sequencer activity and FIFO occupancy
//   fault, fault_code - latched abort (01, residual steps left) or ack timeout (10)
//   pos_x, pos_y - present only with POS_TRACK_EN: accumulated executed position
module corexy_move_sequencer
  import corexy_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DW          = 24,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DW-1:0]            cmd_dx,
  input  logic [DW-1:0]            cmd_dy,
  input  logic [31:0]              cmd_speed_a,
  input  logic [31:0]              cmd_speed_b,
  input  logic                     flush,
  input  logic                     fault_clr,
  output logic [31:0]              stp_step_a,
  output logic [31:0]              stp_speed_a,
  output logic [31:0]              stp_step_b,
  output logic [31:0]              stp_speed_b,
  output logic                     stp_start,
  output logic                     stp_enable,
  input  logic                     stp_driving,
  input  logic [31:0]              stp_rem_a,
  input  logic [31:0]              stp_rem_b,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     fault,
  output logic [1:0]               fault_code
`ifdef POS_TRACK_EN
  ,
  output logic [31:0]              pos_x,
  output logic [31:0]              pos_y
`endif
);

  localparam int CMD_W = $bits(cmd_t);
  localparam int CW    = $clog2(ACK_TIMEOUT + 1);

  state_t           state, state_n;
  logic [1:0]       flt_n;
  cmd_t             cmd_in, head, cmd_q;
  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty, fifo_flush;
  logic             pop, enter_fault;
  logic [31:0]      mv_a, mv_b;
  logic [CW-1:0]    ack_cnt;

  always_comb begin
    cmd_in         = '0;
    cmd_in.dx      = {{(32-DW){cmd_dx[DW-1]}}, cmd_dx};
    cmd_in.dy      = {{(32-DW){cmd_dy[DW-1]}}, cmd_dy};
    cmd_in.speed_a = cmd_speed_a;
    cmd_in.speed_b = cmd_speed_b;
  end

  assign cmd_ready = ~fifo_full;
  assign head      = fifo_dout;

  move_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid & cmd_ready),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // The popped head is parked here; LOAD converts it from this register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cmd_q <= '0;
    else if (pop) cmd_q <= head;
  end

  assign mv_a = motor_a(cmd_q);
  assign mv_b = motor_b(cmd_q);

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_n = state;
    flt_n   = FLT_NONE;
    case (state)
      S_IDLE:
        if (!fifo_empty && !fault && !stp_driving) state_n = S_LOAD;
      S_LOAD:
        // The driver ignores null moves, so never hand it one.
        state_n = (mv_a == '0 && mv_b == '0) ? S_IDLE : S_START;
      S_START:
        if (stp_driving) begin
          state_n = S_RUN;
        end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
          state_n = S_FAULT;
          flt_n   = FLT_TIMEOUT;
        end
      S_RUN:
        if (!stp_driving) state_n = S_CHECK;
      S_CHECK:
        // Any residual count means a limit switch cut the move short.
        if (stp_rem_a == '0 && stp_rem_b == '0) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_FAULT;
          flt_n   = FLT_LIMIT;
        end
      S_FAULT:
        if (fault_clr) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    pop         = (state == S_IDLE) && (state_n == S_LOAD);
    enter_fault = (state != S_FAULT) && (state_n == S_FAULT);
    fifo_flush  = flush | enter_fault;
    stp_start   = (state == S_START);
    stp_enable  = (state != S_FAULT) && !rst;
    busy        = (state != S_IDLE) || !fifo_empty;
  end

  // Ack timeout counter only runs while START is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ack_cnt <= '0;
    else if (state == S_START) ack_cnt <= ack_cnt + 1'b1;
    else                      ack_cnt <= '0;
  end

  // Operands change only in LOAD, so they hold steady for the whole move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stp_step_a  <= '0;
      stp_step_b  <= '0;
      stp_speed_a <= '0;
      stp_speed_b <= '0;
    end else if (state == S_LOAD) begin
      stp_step_a  <= mv_a;
      stp_step_b  <= mv_b;
      stp_speed_a <= cmd_q.speed_a;
      stp_speed_b <= cmd_q.speed_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else if (enter_fault) begin
      fault      <= 1'b1;
      fault_code <= flt_n;
    end else if (state == S_FAULT && fault_clr) begin
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end
  end

`ifdef POS_TRACK_EN
  // Executed steps = commanded - residual; back to XY with x=(A+B)/2, y=(A-B)/2.
  logic [31:0] a_exec, b_exec;
  logic [32:0] sum_x, sum_y;

  assign a_exec = stp_step_a - stp_rem_a;
  assign b_exec = stp_step_b - stp_rem_b;
  assign sum_x  = {a_exec[31], a_exec} + {b_exec[31], b_exec};
  assign sum_y  = {a_exec[31], a_exec} - {b_exec[31], b_exec};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (state == S_CHECK) begin
      pos_x <= pos_x + sum_x[32:1];
      pos_y <= pos_y + sum_y[32:1];
    end
  end
`endif

endmodule
